riscv_dual_fetch_buffer: RTL

Front-end fetch unit for the dual-fetch RISC-V core. It issues paired instruction reads on the two instruction memory ports (imemreq0 for pc, imemreq1 for pc+4). It collects the independently delayed responses from the triple-port random-delay test memory and re-aligns them into in-order instruction pairs for the decode stage. It also handles redirects by flushing buffered pairs and discarding stale in-flight responses.

---
 rtl/riscv_dual_fetch_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/riscv_dual_fetch_buffer.sv
// Dual-port instruction fetch front end.
// Issues paired reads (pc on port 0, pc+4 on port 1), collects the
// independently delayed responses into per-port FIFOs and presents them
// as in-order instruction pairs. A redirect flushes buffered pairs and
// arranges for still-outstanding stale responses to be dropped.
module riscv_dual_fetch_buffer #(
  parameter int          p_depth        = 4,
  parameter logic [31:0] p_reset_vector = 32'h00080000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [66:0] imemreq0_msg,
  output logic        imemreq0_val,
  input  logic        imemreq0_rdy,
  input  logic [34:0] imemresp0_msg,
  input  logic        imemresp0_val,
  output logic [66:0] imemreq1_msg,
  output logic        imemreq1_val,
  input  logic        imemreq1_rdy,
  input  logic [34:0] imemresp1_msg,
  input  logic        imemresp1_val,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1
);

  localparam int AW = $clog2(p_depth);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW + 1)'(p_depth);

  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc;
  logic [CW-1:0] inflight [2];
  logic [CW-1:0] drop     [2];
  logic [CW-1:0] count    [2];
  logic [AW-1:0] head_ptr [2];
  logic [AW-1:0] tail_ptr [2];
  logic [31:0]   fifo     [2][p_depth];

  logic [1:0]    resp_val;
  logic [31:0]   resp_data [2];
  logic [1:0]    has_room;
  logic [1:0]    push;
  logic          can_issue;
  logic          fire;
  logic          pop;
  logic          unused_resp_fields;

  // type/len of responses carry no information for instruction fetch
  assign unused_resp_fields = ^{imemresp0_msg[34:32], imemresp1_msg[34:32]};

  assign resp_val     = {imemresp1_val, imemresp0_val};
  assign resp_data[0] = imemresp0_msg[31:0];
  assign resp_data[1] = imemresp1_msg[31:0];

  // credit check and drop/push decision per port
  always_comb begin
    has_room = '0;
    push     = '0;
    for (int i = 0; i < 2; i++) begin
      has_room[i] = (({1'b0, inflight[i]} + {1'b0, count[i]}) < DEPTH);
      push[i]     = resp_val[i] && (drop[i] == '0) && !redirect_val;
    end
  end

  // both halves of a pair must go out together, so each port's valid
  // waits on the other port's ready; reset gates issue while low
  assign can_issue    = reset && !redirect_val && (&has_room);
  assign imemreq0_val = can_issue && imemreq1_rdy;
  assign imemreq1_val = can_issue && imemreq0_rdy;
  assign fire         = can_issue && imemreq0_rdy && imemreq1_rdy;

  assign imemreq0_msg = {1'b0, fetch_pc, 2'b00, 32'h0};
  assign imemreq1_msg = {1'b0, fetch_pc + 32'd4, 2'b00, 32'h0};

  assign out_val   = (count[0] != '0) && (count[1] != '0) && !redirect_val;
  assign pop       = out_val && out_rdy;
  assign out_pc    = head_pc;
  assign out_inst0 = fifo[0][head_ptr[0]];
  assign out_inst1 = fifo[1][head_ptr[1]];

  // pc tracking, per-port counters and response FIFOs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= p_reset_vector;
      head_pc  <= p_reset_vector;
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= '0;
        drop[i]     <= '0;
        count[i]    <= '0;
        head_ptr[i] <= '0;
        tail_ptr[i] <= '0;
        for (int j = 0; j < p_depth; j++) fifo[i][j] <= '0;
      end
    end else if (redirect_val) begin
      fetch_pc <= redirect_pc;
      head_pc  <= redirect_pc;
      for (int i = 0; i < 2; i++) begin
        // everything still outstanding after this cycle is stale
        inflight[i] <= inflight[i] - CW'(resp_val[i]);
        drop[i]     <= inflight[i] - CW'(resp_val[i]);
        count[i]    <= '0;
        head_ptr[i] <= '0;
        tail_ptr[i] <= '0;
      end
    end else begin
      if (fire) fetch_pc <= fetch_pc + 32'd8;
      if (pop)  head_pc  <= head_pc + 32'd8;
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= inflight[i] + CW'(fire) - CW'(resp_val[i]);
        if (resp_val[i] && (drop[i] != '0)) drop[i] <= drop[i] - CW'(1);
        if (push[i]) begin
          fifo[i][tail_ptr[i]] <= resp_data[i];
          tail_ptr[i]          <= tail_ptr[i] + AW'(1);
        end
        if (pop) head_ptr[i] <= head_ptr[i] + AW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop);
      end
    end
  end

endmodule
